// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock input path and display blocks.
// Holds the BCD digit width, the legal digit limits, the preset_loader FSM
// state encoding and the digit range-check helper.
package clock_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] UNIT_MAX = 4'd9;
  localparam logic [BCD_W-1:0] DEC_MAX  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_REL = 2'd2
  } loader_state_e;

  // True when the digit is legal for the selected position (0 = units, 1 = tens).
  function automatic logic digit_in_range(
    input logic [BCD_W-1:0] digit,
    input logic             sel,
    input logic [BCD_W-1:0] unit_max,
    input logic [BCD_W-1:0] dec_max
  );
    return sel ? (digit <= dec_max) : (digit <= unit_max);
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-low reset
//   raw_i  - raw, asynchronous input
//   deb_o  - debounced level; follows raw_i once it has been stable for
//            DEBOUNCE_CYCLES consecutive synchronised samples
module debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw input and count consecutive cycles of disagreement;
  // the debounced level only flips after a full run of disagreeing samples.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      deb_o   <= 1'b0;
    end else begin
      sync1_r <= raw_i;
      sync2_r <= sync1_r;
      if (sync2_r == deb_o) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        deb_o <= sync2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/preset_loader.sv
// Input conditioning for the seconds counter presets. Debounces the four
// digit buttons and the load button, range-checks the digit against the
// selected position and holds a load request until the counter acknowledges.
// Ports:
//   clk_i, rst_i      - clock, asynchronous active-low reset
//   but_i[3:0]        - raw digit buttons (bit 0 = LSB)
//   load_i            - raw load button, active-high
//   sel_i             - digit target: 0 = units, 1 = tens (synchronised only)
//   load_ack_i        - counter has taken the preset pair
//   preset_unit_o     - stored units digit
//   preset_decimal_o  - stored tens digit
//   load_req_o        - preset pair valid, load requested
//   err_o             - one-cycle pulse on an out-of-range load attempt
//   digit_o           - debounced button value for display preview
module preset_loader
  import clock_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               CNT_W           = 20,
  parameter logic [BCD_W-1:0] UNIT_LIMIT      = clock_pkg::UNIT_MAX,
  parameter logic [BCD_W-1:0] DEC_LIMIT       = clock_pkg::DEC_MAX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BCD_W-1:0] but_i,
  input  logic             load_i,
  input  logic             sel_i,
  input  logic             load_ack_i,
  output logic [BCD_W-1:0] preset_unit_o,
  output logic [BCD_W-1:0] preset_decimal_o,
  output logic             load_req_o,
  output logic             err_o,
  output logic [BCD_W-1:0] digit_o
);

  logic [BCD_W-1:0] but_deb_s;
  logic             load_deb_s;
  logic             load_prev_r;
  logic             load_evt_s;
  logic             sel_sync1_r;
  logic             sel_sync2_r;
  loader_state_e    state_r;

  for (genvar i = 0; i < BCD_W; i++) begin : g_but_deb
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_but_deb (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .raw_i(but_i[i]),
      .deb_o(but_deb_s[i])
    );
  end

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_deb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .raw_i(load_i),
    .deb_o(load_deb_s)
  );

  assign digit_o    = but_deb_s;
  assign load_evt_s = load_deb_s & ~load_prev_r;

  // Slide switch needs only metastability protection, plus the load edge history.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_sync1_r <= 1'b0;
      sel_sync2_r <= 1'b0;
      load_prev_r <= 1'b0;
    end else begin
      sel_sync1_r <= sel_i;
      sel_sync2_r <= sel_sync1_r;
      load_prev_r <= load_deb_s;
    end
  end

  // Load FSM with registered request, error pulse and preset registers.
  // The target digit is captured on the load event, so later switch or
  // button activity cannot disturb a pending request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r          <= ST_IDLE;
      preset_unit_o    <= 4'd0;
      preset_decimal_o <= 4'd0;
      load_req_o       <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Ack is not looked at here: a stray ack must never clear anything.
          if (load_evt_s) begin
            if (digit_in_range(but_deb_s, sel_sync2_r, UNIT_LIMIT, DEC_LIMIT)) begin
              if (sel_sync2_r) begin
                preset_decimal_o <= but_deb_s;
              end else begin
                preset_unit_o <= but_deb_s;
              end
              load_req_o <= 1'b1;
              state_r    <= ST_REQ;
            end else begin
              err_o   <= 1'b1;
              state_r <= ST_WAIT_REL;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (load_ack_i) begin
            load_req_o <= 1'b0;
            state_r    <= ST_WAIT_REL;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT_REL: begin
          // One action per press: wait for the button to be released.
          if (!load_deb_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_REL;
          end
        end
        default: begin
          load_req_o <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preset_loader.sv
// Directed bench for preset_loader with DEBOUNCE_CYCLES = 4.
module tb_preset_loader;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] but_i;
  logic       load_i;
  logic       sel_i;
  logic       load_ack_i;
  logic [3:0] preset_unit_o;
  logic [3:0] preset_decimal_o;
  logic       load_req_o;
  logic       err_o;
  logic [3:0] digit_o;

  int errors = 0;
  int checks = 0;
  int err_cycles = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  int err_base;
  int req_base;
  logic digit_moved;

  preset_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .but_i           (but_i),
    .load_i          (load_i),
    .sel_i           (sel_i),
    .load_ack_i      (load_ack_i),
    .preset_unit_o   (preset_unit_o),
    .preset_decimal_o(preset_decimal_o),
    .load_req_o      (load_req_o),
    .err_o           (err_o),
    .digit_o         (digit_o)
  );

  always #5 clk_i = ~clk_i;

  // Count cycles with err_o high and rising edges of load_req_o.
  always @(posedge clk_i) begin
    #1;
    if (err_o) err_cycles++;
    if (load_req_o && !req_prev) req_rises++;
    req_prev = load_req_o;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0; but_i = 4'd0; load_i = 1'b0; sel_i = 1'b0; load_ack_i = 1'b0;

    // 1. Reset
    cycles(3);
    check_val("rst_req", load_req_o, 1'b0);
    check_val("rst_unit", preset_unit_o, 4'd0);
    check_val("rst_dec", preset_decimal_o, 4'd0);
    check_val("rst_err", err_o, 1'b0);
    check_val("rst_digit", digit_o, 4'd0);
    rst_i = 1'b1;
    err_base = err_cycles; req_base = req_rises;
    cycles(20);
    check_val("idle_err", err_cycles - err_base, 0);
    check_val("idle_req", req_rises - req_base, 0);

    // 2. Units load of 9
    but_i = 4'b1001; sel_i = 1'b0;
    cycles(10);
    check_val("digit9", digit_o, 4'd9);
    load_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1 check_val("req_edge6", load_req_o, 1'b0);
    @(posedge clk_i);
    #1 check_val("req_edge7", load_req_o, 1'b1);
    check_val("unit9", preset_unit_o, 4'd9);
    check_val("dec0", preset_decimal_o, 4'd0);
    cycles(2);
    load_ack_i = 1'b1;
    @(posedge clk_i);
    #1 check_val("req_after_ack", load_req_o, 1'b0);
    @(negedge clk_i) load_ack_i = 1'b0;
    req_base = req_rises;
    cycles(12);
    check_val("no_repeat", req_rises - req_base, 0);
    load_i = 1'b0;
    cycles(10);

    // 3. Tens range error then valid tens
    but_i = 4'b0110; sel_i = 1'b1;
    cycles(10);
    err_base = err_cycles; req_base = req_rises;
    load_i = 1'b1;
    cycles(12);
    check_val("err_one_cycle", err_cycles - err_base, 1);
    check_val("err_dec_kept", preset_decimal_o, 4'd0);
    check_val("err_no_req", req_rises - req_base, 0);
    load_i = 1'b0;
    cycles(10);
    but_i = 4'b0101;
    cycles(10);
    load_i = 1'b1;
    cycles(12);
    check_val("dec5", preset_decimal_o, 4'd5);
    check_val("dec5_req", load_req_o, 1'b1);
    check_val("dec5_unit", preset_unit_o, 4'd9);

    // 5. Freeze during REQ, then stray ack in IDLE
    but_i = 4'b0011; sel_i = 1'b0;
    cycles(10);
    check_val("frz_digit", digit_o, 4'd3);
    check_val("frz_unit", preset_unit_o, 4'd9);
    check_val("frz_dec", preset_decimal_o, 4'd5);
    check_val("frz_req", load_req_o, 1'b1);
    load_ack_i = 1'b1;
    cycles(1);
    load_ack_i = 1'b0;
    check_val("ack2_req", load_req_o, 1'b0);
    load_i = 1'b0;
    cycles(10);
    err_base = err_cycles;
    load_ack_i = 1'b1;
    cycles(2);
    load_ack_i = 1'b0;
    cycles(3);
    check_val("stray_req", load_req_o, 1'b0);
    check_val("stray_err", err_cycles - err_base, 0);
    check_val("stray_unit", preset_unit_o, 4'd9);

    // 4. Glitch rejection
    err_base = err_cycles; req_base = req_rises;
    load_i = 1'b1;
    cycles(3);
    load_i = 1'b0;
    cycles(15);
    check_val("glitch_req", req_rises - req_base, 0);
    check_val("glitch_err", err_cycles - err_base, 0);
    digit_moved = 1'b0;
    but_i = 4'b0000;
    cycles(2);
    but_i = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (digit_o != 4'd3) digit_moved = 1'b1;
    end
    check_val("glitch_digit", digit_moved, 1'b0);

    // FSM still idle after stray ack: a fresh units load of 3 works
    load_i = 1'b1;
    cycles(12);
    check_val("unit3", preset_unit_o, 4'd3);
    check_val("unit3_dec", preset_decimal_o, 4'd5);
    check_val("unit3_req", load_req_o, 1'b1);

    // 6. Asynchronous reset mid-request
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check_val("arst_req", load_req_o, 1'b0);
    check_val("arst_unit", preset_unit_o, 4'd0);
    check_val("arst_dec", preset_decimal_o, 4'd0);
    check_val("arst_digit", digit_o, 4'd0);
    load_i = 1'b0;
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
